// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    function automatic int unsigned cycles_per_bit(input int unsigned clock_freq,
                                                   input int unsigned bit_rate);
        return clock_freq / bit_rate;
    endfunction

    function automatic int unsigned half_bit_cycles(input int unsigned clock_freq,
                                                    input int unsigned bit_rate);
        return cycles_per_bit(clock_freq, bit_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read. A write while full is
// accepted only when a read happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_accept, rd_accept;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign rd_accept = rd_en & ~empty;
    assign wr_accept = wr_en & (~full | rd_en);
    // Head reads as zero while empty so the output is defined out of reset.
    assign rd_data   = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_accept && !rd_accept) begin
                count_q <= count_q + 1'b1;
            end else if (!wr_accept && rd_accept) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronises rx, samples each bit mid-period, checks the
// stop bit and buffers good bytes in a FWFT FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ   = 27000000,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    input  logic                    rd_en,
    output logic [PAYLOAD_BITS-1:0] rd_data,
    output logic                    empty,
    output logic                    full,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int unsigned CPB   = cycles_per_bit(CLOCK_FREQ, BIT_RATE);
    localparam int unsigned HALF  = half_bit_cycles(CLOCK_FREQ, BIT_RATE);
    localparam int unsigned CNT_W = $clog2(CPB + 1);
    localparam int unsigned BIT_W = $clog2(PAYLOAD_BITS + 1);
    localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

    logic       sync1_q, rx_s_q;
    logic [1:0] sync_vld_q;
    logic       seen_high_q;

    // sync_vld_q masks the reset value of the synchroniser so that a line held
    // low through reset is never mistaken for an idle-high line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            sync_vld_q  <= '0;
            seen_high_q <= 1'b0;
        end else begin
            sync1_q    <= rx;
            rx_s_q     <= sync1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            if (sync_vld_q[1] && rx_s_q) begin
                seen_high_q <= 1'b1;
            end
        end
    end

    rx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    push;
    logic                    frame_err_d, frame_err_q;
    logic                    overrun_d, overrun_q;
    logic [FCW-1:0]          fifo_count;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (seen_high_q && !rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CNT_W'(CPB - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[PAYLOAD_BITS-1:1]};
                    if (bit_q == BIT_W'(PAYLOAD_BITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CNT_W'(CPB - 1)) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A simultaneous pop frees the slot, so only an unaccompanied push is lost.
    assign overrun_d = push & (fifo_count == FCW'(FIFO_DEPTH)) & ~rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    sync_fifo #(
        .WIDTH(PAYLOAD_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (push),
        .wr_data(shift_d),
        .rd_en  (rd_en),
        .rd_data(rd_data),
        .empty  (empty),
        .full   (full),
        .count  (fifo_count)
    );

endmodule
